uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart transmitter among N_REQ requesters using round-robin arbitration.
//  Each transfer sends one DATA_W-bit word. The block drives the uart data_in/data_en inputs
//  and uses tx_busy to track each transfer. It reports per-requester grant and completion,
//  and flags a timeout when the uart never starts. It sits between the client logic and the
//  uart TX side; the RX side is not touched.
// PARAMETERS
//  N_REQ          4   number of requesters, >=2; need not be a power of two
//  DATA_W         4   width of one transmitted word; matches the uart data_in width
//  START_TIMEOUT  16  max cycles in WAIT_START for tx_busy to rise before abort, >=2
// PORTS
//  clk          in   1             system clock, rising edge
//  rstn         in   1             asynchronous active-low reset
//  req_i        in   N_REQ         level request, one bit per requester
//  req_data_i   in   N_REQ*DATA_W  word for requester k at [k*DATA_W +: DATA_W]
//  grant_o      out  N_REQ         one-hot, high while requester k owns the uart
//  done_o       out  N_REQ         1-cycle pulse to the owner when its transfer ends
//  err_o        out  1             1-cycle pulse with done_o when the transfer timed out
//  busy_o       out  1             high whenever state != IDLE
//  data_in      out  DATA_W        to uart data_in; holds the latched word while granted
//  data_en      out  1             to uart data_en; 1-cycle start pulse
//  tx_busy      in   1             from uart; high while a frame is on the line
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: all outputs 0, state IDLE, ptr 0, timeout counter 0.
//  - States and transitions:
//    IDLE:       if |req_i && !tx_busy: winner = first set req bit searching ptr, ptr+1, ...
//                (mod N_REQ). Latch winner index and its data into data_in; set grant_o[winner];
//                go to LAUNCH.
//    LAUNCH:     data_en=1 for exactly this cycle; clear counter; go to WAIT_START.
//    WAIT_START: tx_busy=1 -> WAIT_DONE. Otherwise counter++.
//                Counter==START_TIMEOUT-1 -> ABORT path.
//    WAIT_DONE:  tx_busy=0 -> COMPLETE path. No timeout in this state.
//    COMPLETE/ABORT (next edge): done_o[winner]=1 (and err_o=1 if ABORT); grant_o cleared;
//                ptr = (winner+1) mod N_REQ; return to IDLE.
//  - Latency: req sampled in cycle 0 with tx_busy low -> grant_o and data_in valid in cycle 1,
//    data_en in cycle 2; done_o 1 cycle after tx_busy falls.
//  - Back-to-back: minimum 1 IDLE cycle between done_o and the next grant.
//  - Handshake rules:
//    - A requester holds req until it sees its done_o pulse and drops req in that same cycle.
//    - A req still high in the IDLE cycle after done_o is a new request.
//    - Requests are not re-issued in hardware; the requester must re-request after err_o.
//  - Data is latched at grant; later changes to req_data_i or req_i are ignored until done_o.
//  - Dropping req mid-transfer does not abort the transfer.
//  - tx_busy high in IDLE (uart left mid-frame, e.g. after controller reset): no grant is
//    issued until tx_busy is low.
//  - Timeout (tx_busy never rises): err_o pulses with done_o; ptr still advances so a stuck
//    requester cannot starve the others.
//  - Simultaneous requests: the highest priority is ptr, then ptr+1 ... wrapping at N_REQ-1 -> 0.
//  - Async reset mid-transfer: data_en, grant_o and done_o go to 0 immediately; the transfer is
//    lost with no done_o; ptr returns to 0.
//  - Widths: ptr and winner are $clog2(N_REQ) bits; the counter is $clog2(START_TIMEOUT+1) bits.
//    Wrap uses an explicit compare to N_REQ-1, not a power-of-two overflow.
// STRUCTURE
//  - Package uart_ctrl_pkg: state enum
//    (ST_IDLE, ST_LAUNCH, ST_WAIT_START, ST_WAIT_DONE, ST_END); ST_END covers COMPLETE/ABORT.
//    Also holds the default DATA_W constant shared with the uart.
//  - Sub-module rr_arbiter: combinational round-robin picker.
//    Parameter N; inputs req, ptr; outputs winner index and any_valid.
//  - The FSM, latches and timeout counter live in this module.
// TESTING (bench instantiates the uart with CLOCKS_PER_PULSE=4, TX looped back to RX)
//  1. Single request: req_i=4'b0100, data=4'hA -> grant_o=0100, one data_en pulse,
//     uart receives 4'hA, done_o[2] pulses once, err_o=0, ptr=3.
//  2. All four requesting, data k=4'h1..4'h4, ptr=0 -> grants in order 0,1,2,3;
//     received words 1,2,3,4; each done_o pulses exactly once.
//  3. Wrap and fairness: ptr=3, req=4'b1001 -> grant 3 then 0; requester 0 held high
//     throughout -> never granted twice before requester 3.
//  4. Timeout: tx_busy forced 0 -> err_o and done_o pulse together exactly START_TIMEOUT
//     cycles after the data_en pulse; next request is served normally.
//  5. Reset mid-frame: rstn low during WAIT_DONE -> all outputs 0 immediately; after release
//     with req high, no grant until tx_busy falls; then the word transfers correctly.
//  6. Data change after grant: req_data_i changes during WAIT_DONE -> uart receives the
//     original word; data_in is stable until done_o.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state type and data width for the uart controller
package uart_ctrl_pkg;
  localparam int UART_DATA_W = 4;
  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT_START, ST_WAIT_DONE, ST_END} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set req bit at or after ptr wins
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_valid
);
  localparam int PW = $clog2(N);
  int idx;
  always_comb begin
    winner = '0;
    any_valid = |req;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      idx = (idx >= N) ? idx - N : idx;
      winner = req[PW'(idx)] ? PW'(idx) : winner;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter among N_REQ requesters
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = UART_DATA_W,
  parameter int START_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [N_REQ-1:0]          done_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [DATA_W-1:0]         data_in,
  output logic                      data_en,
  input  logic                      tx_busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  state_t            state;
  logic [PW-1:0]     ptr, winner, pick;
  logic [CW-1:0]     cnt;
  logic              any_valid, timeout, fin;
  logic [DATA_W-1:0] words [N_REQ];
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_i),
    .ptr       (ptr),
    .winner    (pick),
    .any_valid (any_valid)
  );
  always_comb begin
    for (int k = 0; k < N_REQ; k++) words[k] = req_data_i[k*DATA_W +: DATA_W];
  end
  assign timeout = (state == ST_WAIT_START) && !tx_busy && (cnt == CW'(START_TIMEOUT - 1));
  assign fin     = timeout || ((state == ST_WAIT_DONE) && !tx_busy);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      winner  <= '0;
      cnt     <= '0;
      grant_o <= '0;
      done_o  <= '0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      data_in <= '0;
      data_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any_valid && !tx_busy) begin
          winner  <= pick;
          data_in <= words[pick];
          grant_o <= N_REQ'(1) << pick;
          busy_o  <= 1'b1;
          state   <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          data_en <= 1'b1;
          cnt     <= '0;
          state   <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          data_en <= 1'b0;
          if (tx_busy) state <= ST_WAIT_DONE;
          else if (!timeout) cnt <= cnt + 1'b1;
        end
        ST_WAIT_DONE: ;
        ST_END: begin
          done_o <= '0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (fin) begin
        done_o  <= N_REQ'(1) << winner;
        err_o   <= timeout;
        grant_o <= '0;
        ptr     <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        state   <= ST_END;
      end
    end
  end
endmodule
